// File: rtl/mem_access_unit.sv
// mem_access_unit
//   MEM-stage load/store unit of the pipelined MIPS core. It takes one load
//   or store per cycle and acts as the initiator towards a byte-addressed,
//   little-endian data memory. That memory reads combinationally and writes
//   one 32-bit word on the clock edge.
//
//   Loads read the aligned word. The addressed lane is extracted, extended
//   and registered, so the result is ready one cycle after the request.
//   Word stores write in a single cycle. Byte and half stores use a
//   read-modify-write: the word is read with stall high, and the merged word
//   is written in the following cycle.
//
//   Handshake: a request is offered while req_valid=1. It is consumed on the
//   rising edge at the end of the cycle unless stall=1. When stall=1 the
//   pipeline holds every req_* input stable for one more cycle. In that
//   cycle (WRITE) the unit ignores the inputs, so the held store is not
//   accepted a second time.
//
// Ports
//   clock, reset          rising-edge clock, synchronous active-high reset
//   req_*                 request from the MEM stage
//   stall                 combinational pipeline hold (first RMW cycle)
//   load_data/load_valid  registered load result and its one-cycle pulse
//   err                   one-cycle pulse: misaligned access or illegal size
//   mem_*                 data memory interface (mem_ReadData is the input)
//   state_dbg             current FSM state (0 = IDLE, 1 = WRITE)

module mem_access_unit #(
  parameter int bAddress = 8,
  parameter int bData    = 32
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                req_valid,
  input  logic                req_write,
  input  logic [1:0]          req_size,
  input  logic                req_signed,
  input  logic [bAddress-1:0] req_addr,
  input  logic [bData-1:0]    req_wdata,
  output logic                stall,
  output logic [bData-1:0]    load_data,
  output logic                load_valid,
  output logic                err,
  output logic [bAddress-1:0] mem_Address,
  output logic [bData-1:0]    mem_WriteData,
  output logic                mem_enReadMem,
  output logic                mem_enWriteMem,
  input  logic [bData-1:0]    mem_ReadData,
  output logic                state_dbg
);

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic {IDLE = 1'b0, WRITE = 1'b1} state_t;

  state_t              state;
  logic [bAddress-1:0] waddr_q;
  logic [bData-1:0]    merged_q;

  logic [bAddress-1:0] waddr;
  logic [1:0]          lane;
  logic                access_ok;
  logic [bData-1:0]    shifted;
  logic [bData-1:0]    load_ext;
  logic [bData-1:0]    merged_next;

  assign lane      = req_addr[1:0];
  assign waddr     = {req_addr[bAddress-1:2], 2'b00};
  assign state_dbg = (state == WRITE);

  // Alignment check. The illegal size 11 is also treated as "not ok".
  always_comb begin
    access_ok = 1'b0;
    case (req_size)
      SZ_BYTE: access_ok = 1'b1;
      SZ_HALF: access_ok = (lane[0] == 1'b0);
      SZ_WORD: access_ok = (lane == 2'b00);
      default: access_ok = 1'b0;
    endcase
  end

  // Shift the addressed lane down to bit 0. The access is aligned, so a
  // half never straddles the word.
  assign shifted = mem_ReadData >> {lane, 3'b000};

  always_comb begin
    load_ext = shifted;
    case (req_size)
      SZ_BYTE: load_ext = {{(bData-8){req_signed & shifted[7]}}, shifted[7:0]};
      SZ_HALF: load_ext = {{(bData-16){req_signed & shifted[15]}}, shifted[15:0]};
      default: load_ext = mem_ReadData;
    endcase
  end

  // Replace the addressed byte lanes of the word just read with the store
  // data. The low half of the store data goes to the even byte.
  always_comb begin
    merged_next = mem_ReadData;
    for (int i = 0; i < 4; i++) begin
      if (req_size == SZ_BYTE && lane == 2'(i))
        merged_next[8*i +: 8] = req_wdata[7:0];
      else if (req_size == SZ_HALF && lane[1] == i[1])
        merged_next[8*i +: 8] = i[0] ? req_wdata[15:8] : req_wdata[7:0];
    end
  end

  // Memory drive and stall. Everything is forced to 0 while reset is high,
  // which also suppresses a pending RMW write. Address and write data read
  // 0 whenever no access is enabled.
  always_comb begin
    stall          = 1'b0;
    mem_enReadMem  = 1'b0;
    mem_enWriteMem = 1'b0;
    mem_Address    = '0;
    mem_WriteData  = '0;
    if (!reset) begin
      if (state == WRITE) begin
        mem_enWriteMem = 1'b1;
        mem_Address    = waddr_q;
        mem_WriteData  = merged_q;
      end else if (req_valid && access_ok) begin
        mem_Address = waddr;
        if (!req_write) begin
          mem_enReadMem = 1'b1;
        end else if (req_size == SZ_WORD) begin
          mem_enWriteMem = 1'b1;
          mem_WriteData  = req_wdata;
        end else begin
          mem_enReadMem = 1'b1;
          stall         = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      load_data  <= '0;
      load_valid <= 1'b0;
      err        <= 1'b0;
      merged_q   <= '0;
      waddr_q    <= '0;
    end else begin
      load_valid <= 1'b0;
      err        <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            if (!access_ok) begin
              err <= 1'b1;
            end else if (!req_write) begin
              load_data  <= load_ext;
              load_valid <= 1'b1;
            end else if (req_size != SZ_WORD) begin
              merged_q <= merged_next;
              waddr_q  <= waddr;
              state    <= WRITE;
            end
          end
        end
        WRITE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed load/store vectors against a small
// word-array memory. The driver pushes the expected responses and memory
// writes into queues. A negedge monitor pops and compares them whenever the
// DUT pulses load_valid/err or enables a memory write.

module tb_mem_access_unit;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // ---------------- DUT ----------------
  logic        req_valid = 1'b0, req_write = 1'b0, req_signed = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic [7:0]  req_addr = 8'h00;
  logic [31:0] req_wdata = 32'h0;
  logic        stall, load_valid, err, mem_enReadMem, mem_enWriteMem, state_dbg;
  logic [31:0] load_data, mem_WriteData, mem_ReadData;
  logic [7:0]  mem_Address;

  mem_access_unit #(.bAddress(8), .bData(32)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_write(req_write), .req_size(req_size),
    .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .stall(stall), .load_data(load_data), .load_valid(load_valid), .err(err),
    .mem_Address(mem_Address), .mem_WriteData(mem_WriteData),
    .mem_enReadMem(mem_enReadMem), .mem_enWriteMem(mem_enWriteMem),
    .mem_ReadData(mem_ReadData), .state_dbg(state_dbg)
  );

  // Data memory: 64 words, combinational read, word write on the edge.
  logic [31:0] mem [0:63];
  assign mem_ReadData = mem[mem_Address[7:2]];
  always @(posedge clock) if (mem_enWriteMem) mem[mem_Address[7:2]] <= mem_WriteData;

  // ---------------- scoreboard ----------------
  int tests = 0;
  int fails = 0;
  logic [64:0] exp_q[$];    // {due cycle[31:0], err, load_data[31:0]}
  logic [39:0] exp_w_q[$];  // {address[7:0], write data[31:0]}
  logic [31:0] last_load = 32'h0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name, input logic [63:0] act);
    tests++;
    fails++;
    $display("FAIL %s: got %h with nothing expected (cycle %0d)", name, act, cyc);
  endtask

  always @(negedge clock) begin
    logic [64:0] e;
    logic [39:0] w;
    if (!reset) begin
      if (mem_enReadMem || mem_enWriteMem)
        check("rd_wr_exclusive", {63'd0, mem_enReadMem & mem_enWriteMem}, 64'd0);
      if (load_valid || err) begin
        check("err_lv_exclusive", {63'd0, load_valid & err}, 64'd0);
        if (exp_q.size() == 0) begin
          fail_now("unexpected_resp", {31'd0, err, load_data});
        end else begin
          e = exp_q.pop_front();
          check("resp_cycle", 64'(cyc), {32'd0, e[64:33]});
          check("resp_err", {63'd0, err}, {63'd0, e[32]});
          check("load_data", {32'd0, load_data}, {32'd0, e[31:0]});
        end
      end
      if (mem_enWriteMem) begin
        if (exp_w_q.size() == 0) begin
          fail_now("unexpected_write", {24'd0, mem_Address, mem_WriteData});
        end else begin
          w = exp_w_q.pop_front();
          check("write_addr_data", {24'd0, mem_Address, mem_WriteData}, {24'd0, w});
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called just after a rising edge. For stores, exp_val is the expected
  // written word; for loads it is the expected load_data.
  task automatic req(input logic wr, input logic [1:0] sz, input logic sgn,
                     input logic [7:0] addr, input logic [31:0] wd,
                     input logic [31:0] exp_val, input logic exp_err);
    logic sub;
    sub = wr && (sz != 2'b10) && !exp_err;
    req_valid = 1'b1; req_write = wr; req_size = sz; req_signed = sgn;
    req_addr = addr; req_wdata = wd;
    if (exp_err) begin
      exp_q.push_back({32'(cyc + 1), 1'b1, last_load});
    end else if (!wr) begin
      exp_q.push_back({32'(cyc + 1), 1'b0, exp_val});
      last_load = exp_val;
    end else begin
      exp_w_q.push_back({addr & 8'hFC, exp_val});
    end
    @(negedge clock);
    check("stall", {63'd0, stall}, {63'd0, sub});
    if (exp_err) begin
      check("err_no_enables", {62'd0, mem_enReadMem, mem_enWriteMem}, 64'd0);
    end else if (!wr || sub) begin
      check("read_enable", {63'd0, mem_enReadMem}, 64'd1);
      check("read_addr", {56'd0, mem_Address}, {56'd0, addr & 8'hFC});
    end
    @(posedge clock); #1;
    if (sub) begin
      @(negedge clock);
      check("write_cycle_stall", {63'd0, stall}, 64'd0);
      check("write_cycle_state", {63'd0, state_dbg}, 64'd1);
      @(posedge clock); #1;
    end
  endtask

  task automatic idle();
    req_valid = 1'b0;
    @(negedge clock);
    check("idle_no_enables", {62'd0, mem_enReadMem, mem_enWriteMem}, 64'd0);
    @(posedge clock); #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    mem[0]  = 32'hFFFF_EEEE;
    mem[1]  = 32'h0000_000E;
    mem[63] = 32'hFFFF_EEEE;

    // Reset with a load request present: nothing may reach memory.
    reset = 1'b1; req_valid = 1'b1; req_size = 2'b10; req_addr = 8'h00;
    @(posedge clock);
    @(negedge clock);
    check("rst_stall", {63'd0, stall}, 64'd0);
    check("rst_load_valid", {63'd0, load_valid}, 64'd0);
    check("rst_err", {63'd0, err}, 64'd0);
    check("rst_load_data", {32'd0, load_data}, 64'd0);
    check("rst_enables", {62'd0, mem_enReadMem, mem_enWriteMem}, 64'd0);
    check("rst_addr_wdata", {24'd0, mem_Address, mem_WriteData}, 64'd0);
    check("rst_state", {63'd0, state_dbg}, 64'd0);
    @(posedge clock); #1;
    reset = 1'b0; req_valid = 1'b0;
    idle();

    // Back-to-back loads from word0 = FFFFEEEE.
    req(1'b0, 2'b00, 1'b1, 8'd1, 32'h0, 32'hFFFF_FFEE, 1'b0);  // lb
    req(1'b0, 2'b00, 1'b0, 8'd1, 32'h0, 32'h0000_00EE, 1'b0);  // lbu
    req(1'b0, 2'b01, 1'b1, 8'd2, 32'h0, 32'hFFFF_FFFF, 1'b0);  // lh
    req(1'b0, 2'b01, 1'b0, 8'd0, 32'h0, 32'h0000_EEEE, 1'b0);  // lhu
    idle();

    // sb into word4, then read it back.
    req(1'b1, 2'b00, 1'b0, 8'd5, 32'h1234_565A, 32'h0000_5A0E, 1'b0);
    req(1'b0, 2'b10, 1'b0, 8'd4, 32'h0, 32'h0000_5A0E, 1'b0);
    // sh at the top word of memory.
    req(1'b1, 2'b01, 1'b0, 8'd254, 32'h0000_BEEF, 32'hBEEF_EEEE, 1'b0);
    idle();

    // Misaligned / illegal requests: err pulses, load_data held.
    req(1'b0, 2'b10, 1'b0, 8'd6, 32'h0, 32'h0, 1'b1);
    req(1'b1, 2'b01, 1'b0, 8'd3, 32'h0000_BEEF, 32'h0, 1'b1);
    req(1'b0, 2'b11, 1'b0, 8'd0, 32'h0, 32'h0, 1'b1);
    idle();

    // sb with reset asserted in its WRITE cycle: write suppressed.
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'b00; req_signed = 1'b0;
    req_addr = 8'd0; req_wdata = 32'h0000_0077;
    @(negedge clock);
    check("rmw_rst_stall", {63'd0, stall}, 64'd1);
    @(posedge clock); #1;
    reset = 1'b1;
    @(negedge clock);
    check("rmw_rst_no_write", {63'd0, mem_enWriteMem}, 64'd0);
    check("rmw_rst_stall_low", {63'd0, stall}, 64'd0);
    @(posedge clock); #1;
    reset = 1'b0; req_valid = 1'b0; last_load = 32'h0;
    @(negedge clock);
    check("rmw_rst_state", {63'd0, state_dbg}, 64'd0);
    check("rmw_rst_mem0", {32'd0, mem[0]}, {32'd0, 32'hFFFF_EEEE});
    check("rmw_rst_load_data", {32'd0, load_data}, 64'd0);
    @(posedge clock); #1;
    req(1'b0, 2'b10, 1'b0, 8'd0, 32'h0, 32'hFFFF_EEEE, 1'b0);

    // Alternating sw, lw, sb, lw with no idle cycles in between.
    req(1'b1, 2'b10, 1'b0, 8'd8,  32'hA1B2_C3D4, 32'hA1B2_C3D4, 1'b0);
    req(1'b0, 2'b10, 1'b0, 8'd8,  32'h0,         32'hA1B2_C3D4, 1'b0);
    req(1'b1, 2'b00, 1'b0, 8'd10, 32'h0000_0099, 32'hA199_C3D4, 1'b0);
    req(1'b0, 2'b10, 1'b0, 8'd8,  32'h0,         32'hA199_C3D4, 1'b0);
    req(1'b0, 2'b01, 1'b1, 8'd10, 32'h0,         32'hFFFF_A199, 1'b0);
    // Consecutive sub-word stores to the same word.
    req(1'b1, 2'b00, 1'b0, 8'd12, 32'h0000_0011, 32'h0000_0011, 1'b0);
    req(1'b1, 2'b00, 1'b0, 8'd13, 32'h0000_0022, 32'h0000_2211, 1'b0);
    req(1'b0, 2'b10, 1'b0, 8'd12, 32'h0,         32'h0000_2211, 1'b0);
    idle();
    idle();

    for (int i = 0; i < 20 && (exp_q.size() != 0 || exp_w_q.size() != 0); i++)
      @(posedge clock);
    check("resp_queue_drained", 64'(exp_q.size()), 64'd0);
    check("write_queue_drained", 64'(exp_w_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
